// File: rtl/rtc_apb_ctrl.sv
// rtc_apb_ctrl: APB register front-end for the RTC core.
// Turns CPU writes of CLOCK/ALARM/TIMER into single-cycle load pulses,
// latches event/day-rollover into sticky interrupt status, counts days
// and drives a registered level interrupt.
// Optional build macro RTC_BCD_CHECK_EN: rejects CLOCK/ALARM writes that
// are not a legal BCD time of day (slave error, no pulse, no load).
module rtc_apb_ctrl #(
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      clock_update_o,
    output logic [21:0]               clock_o,
    output logic [9:0]                init_sec_cnt_o,
    input  logic [21:0]               clock_i,
    output logic                      alarm_update_o,
    output logic                      alarm_enable_o,
    output logic [21:0]               alarm_clock_o,
    input  logic [21:0]               alarm_clock_i,
    output logic                      timer_update_o,
    output logic                      timer_enable_o,
    output logic                      timer_retrig_o,
    output logic [16:0]               timer_target_o,
    input  logic [16:0]               timer_value_i,
    input  logic                      event_i,
    input  logic                      update_day_i,
    output logic                      irq_o
);

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CTRL    = 3'd1;
    localparam logic [2:0] REG_CLOCK   = 3'd2;
    localparam logic [2:0] REG_ALARM   = 3'd3;
    localparam logic [2:0] REG_TIMER   = 3'd4;
    localparam logic [2:0] REG_TVAL    = 3'd5;
    localparam logic [2:0] REG_INITSEC = 3'd6;
    localparam logic [2:0] REG_DAYCNT  = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_UPD  = 1'b1
    } state_t;

    state_t state_reg, state_next;
    logic [2:0] upd_idx_reg, upd_idx_next;

    logic [1:0]  status_reg, status_next, status_set;
    logic [1:0]  ctrl_reg;
    logic [15:0] daycnt_reg;
    logic [9:0]  initsec_reg;
    logic        irq_reg;

    logic [21:0] clock_reg;
    logic [9:0]  init_sec_cnt_reg;
    logic [21:0] alarm_clock_reg;
    logic        alarm_en_reg;
    logic [16:0] timer_target_reg;
    logic        timer_retrig_reg;
    logic        timer_en_reg;

    logic                      access;
    logic [2:0]                reg_idx;
    logic [APB_ADDR_WIDTH-1:0] addr_hi;
    logic                      unmapped;
    logic                      is_pulse_reg;
    logic                      bcd_fail;
    logic                      pready_c, pslverr_c;
    logic                      reg_wr;
    logic                      load_clock, load_alarm, load_timer;
    logic                      status_w1c;
    logic [31:0]               rd_data;
    logic                      rd_en;

    assign access   = PSEL & PENABLE;
    assign reg_idx  = PADDR[4:2];
    // The map ends at 0x1C; anything from 0x20 upward is a slave error.
    assign addr_hi  = PADDR >> 5;
    assign unmapped = |addr_hi;
    assign is_pulse_reg = (reg_idx == REG_CLOCK) || (reg_idx == REG_ALARM) ||
                          (reg_idx == REG_TIMER);

`ifdef RTC_BCD_CHECK_EN
    // Legal time of day: each BCD digit in range, hh<=23, spare bits clear.
    // Bit 31 is the alarm enable, so it is only required to be 0 for CLOCK.
    function automatic logic bcd_time_ok(input logic [31:0] d, input logic check_msb);
        logic ok;
        ok = (d[30:22] == 9'd0) && !(check_msb && d[31]);
        ok = ok && (d[3:0] <= 4'd9) && (d[7:4] <= 4'd5);
        ok = ok && (d[11:8] <= 4'd9) && (d[15:12] <= 4'd5);
        ok = ok && (d[19:16] <= 4'd9) && (d[21:20] <= 2'd2);
        ok = ok && !((d[21:20] == 2'd2) && (d[19:16] > 4'd3));
        return ok;
    endfunction

    assign bcd_fail = ((reg_idx == REG_CLOCK) || (reg_idx == REG_ALARM)) &&
                      !bcd_time_ok(PWDATA, reg_idx == REG_CLOCK);
`else
    assign bcd_fail = 1'b0;
`endif

    // Transfer decode and IDLE/UPD sequencing for the load-pulse registers.
    always_comb begin
        state_next   = state_reg;
        upd_idx_next = upd_idx_reg;
        pready_c     = 1'b0;
        pslverr_c    = 1'b0;
        reg_wr       = 1'b0;
        load_clock   = 1'b0;
        load_alarm   = 1'b0;
        load_timer   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (access) begin
                    if (unmapped || (PWRITE && is_pulse_reg && bcd_fail)) begin
                        pready_c  = 1'b1;
                        pslverr_c = 1'b1;
                    end else if (PWRITE && is_pulse_reg) begin
                        // One wait state: load now, pulse in UPD.
                        load_clock   = (reg_idx == REG_CLOCK);
                        load_alarm   = (reg_idx == REG_ALARM);
                        load_timer   = (reg_idx == REG_TIMER);
                        upd_idx_next = reg_idx;
                        state_next   = ST_UPD;
                    end else begin
                        pready_c = 1'b1;
                        reg_wr   = PWRITE;
                    end
                end
            end
            ST_UPD: begin
                // Committed transfer: pulse regardless of PSEL.
                pready_c   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state and pending-pulse selector.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_reg   <= ST_IDLE;
            upd_idx_reg <= REG_STATUS;
        end else begin
            state_reg   <= state_next;
            upd_idx_reg <= upd_idx_next;
        end
    end

    // Sticky status bits: a new event outranks a simultaneous W1C.
    assign status_set = {update_day_i, event_i};
    assign status_w1c = reg_wr && (reg_idx == REG_STATUS);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sticky
            assign status_next[gi] = status_set[gi] |
                                     (status_reg[gi] & ~(status_w1c & PWDATA[gi]));
        end
    endgenerate

    // Status, control, day counter, INITSEC and the registered interrupt.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            status_reg  <= 2'b00;
            ctrl_reg    <= 2'b00;
            daycnt_reg  <= 16'h0000;
            initsec_reg <= 10'd0;
            irq_reg     <= 1'b0;
        end else begin
            status_reg <= status_next;
            irq_reg    <= |(status_reg & ctrl_reg);
            if (reg_wr && (reg_idx == REG_CTRL)) begin
                ctrl_reg <= PWDATA[1:0];
            end
            if (reg_wr && (reg_idx == REG_INITSEC)) begin
                initsec_reg <= PWDATA[9:0];
            end
            if (reg_wr && (reg_idx == REG_DAYCNT)) begin
                daycnt_reg <= PWDATA[15:0];
            end else if (update_day_i) begin
                daycnt_reg <= daycnt_reg + 16'd1;
            end
        end
    end

    // Values presented to the core; they hold after the load pulse.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            clock_reg        <= 22'd0;
            init_sec_cnt_reg <= 10'd0;
            alarm_clock_reg  <= 22'd0;
            alarm_en_reg     <= 1'b0;
            timer_target_reg <= 17'd0;
            timer_retrig_reg <= 1'b0;
            timer_en_reg     <= 1'b0;
        end else begin
            if (load_clock) begin
                clock_reg        <= PWDATA[21:0];
                init_sec_cnt_reg <= initsec_reg;
            end
            if (load_alarm) begin
                alarm_clock_reg <= PWDATA[21:0];
                alarm_en_reg    <= PWDATA[31];
            end
            if (load_timer) begin
                timer_target_reg <= PWDATA[16:0];
                timer_retrig_reg <= PWDATA[30];
                timer_en_reg     <= PWDATA[31];
            end
        end
    end

    // Read mux; write-only TIMER reads back as zero.
    always_comb begin
        rd_data = 32'd0;
        case (reg_idx)
            REG_STATUS:  rd_data = {30'd0, status_reg};
            REG_CTRL:    rd_data = {30'd0, ctrl_reg};
            REG_CLOCK:   rd_data = {10'd0, clock_i};
            REG_ALARM:   rd_data = {alarm_en_reg, 9'd0, alarm_clock_i};
            REG_TIMER:   rd_data = 32'd0;
            REG_TVAL:    rd_data = {15'd0, timer_value_i};
            REG_INITSEC: rd_data = {22'd0, initsec_reg};
            REG_DAYCNT:  rd_data = {16'd0, daycnt_reg};
            default:     rd_data = 32'd0;
        endcase
    end

    assign rd_en   = access && !PWRITE && (state_reg == ST_IDLE) && !unmapped;
    assign PRDATA  = (rstn_i && rd_en) ? rd_data : 32'd0;
    assign PREADY  = rstn_i & pready_c;
    assign PSLVERR = rstn_i & pslverr_c;

    assign clock_update_o = rstn_i && (state_reg == ST_UPD) && (upd_idx_reg == REG_CLOCK);
    assign alarm_update_o = rstn_i && (state_reg == ST_UPD) && (upd_idx_reg == REG_ALARM);
    assign timer_update_o = rstn_i && (state_reg == ST_UPD) && (upd_idx_reg == REG_TIMER);

    assign clock_o        = clock_reg;
    assign init_sec_cnt_o = init_sec_cnt_reg;
    assign alarm_clock_o  = alarm_clock_reg;
    assign alarm_enable_o = alarm_en_reg;
    assign timer_target_o = timer_target_reg;
    assign timer_retrig_o = timer_retrig_reg;
    assign timer_enable_o = timer_en_reg;
    assign irq_o          = irq_reg;

endmodule

// File: tb/tb_rtc_apb_ctrl.sv
// Testbench for rtc_apb_ctrl: APB responses and load pulses are checked by
// monitors against queues filled by the stimulus tasks from a register-level
// model of the block.
module tb_rtc_apb_ctrl;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        clock_update_o, alarm_update_o, timer_update_o;
    logic [21:0] clock_o, clock_i, alarm_clock_o, alarm_clock_i;
    logic [9:0]  init_sec_cnt_o;
    logic        alarm_enable_o, timer_enable_o, timer_retrig_o;
    logic [16:0] timer_target_o, timer_value_i;
    logic        event_i, update_day_i, irq_o;

    always #5 clk_i = ~clk_i;

    rtc_apb_ctrl #(.APB_ADDR_WIDTH(12)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .clock_update_o(clock_update_o), .clock_o(clock_o),
        .init_sec_cnt_o(init_sec_cnt_o), .clock_i(clock_i),
        .alarm_update_o(alarm_update_o), .alarm_enable_o(alarm_enable_o),
        .alarm_clock_o(alarm_clock_o), .alarm_clock_i(alarm_clock_i),
        .timer_update_o(timer_update_o), .timer_enable_o(timer_enable_o),
        .timer_retrig_o(timer_retrig_o), .timer_target_o(timer_target_o),
        .timer_value_i(timer_value_i), .event_i(event_i),
        .update_day_i(update_day_i), .irq_o(irq_o)
    );

    logic [111:0] all_outs;
    assign all_outs = {PRDATA, PREADY, PSLVERR, clock_update_o, clock_o, init_sec_cnt_o,
                       alarm_update_o, alarm_enable_o, alarm_clock_o, timer_update_o,
                       timer_enable_o, timer_retrig_o, timer_target_o, irq_o};

    // Register-level model of the block.
    logic        m_evt, m_day;
    logic [1:0]  m_ctrl;
    logic [15:0] m_daycnt;
    logic [9:0]  m_initsec, m_isec_cnt;
    logic [21:0] m_clock, m_alarm;
    logic        m_alarm_en, m_ten, m_tretrig;
    logic [16:0] m_ttarget;

    typedef struct {
        string       name;
        int          waits;
        logic        err;
        bit          is_rd;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic [2:0]  kind;   // {clock, alarm, timer}
        logic [21:0] clk;
        logic [9:0]  isec;
        logic [21:0] alm;
        logic        alm_en;
        logic [16:0] tgt;
        logic        rt;
        logic        ten;
    } pexp_t;

    exp_t  exp_q[$];
    pexp_t pulse_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic model_irq();
        return (m_evt & m_ctrl[0]) | (m_day & m_ctrl[1]);
    endfunction

    function automatic void model_reset();
        m_evt = 0; m_day = 0; m_ctrl = 0; m_daycnt = 0; m_initsec = 0; m_isec_cnt = 0;
        m_clock = 0; m_alarm = 0; m_alarm_en = 0; m_ten = 0; m_tretrig = 0; m_ttarget = 0;
    endfunction

    function automatic pexp_t snap(input logic [2:0] kind);
        pexp_t p;
        p.kind = kind; p.clk = m_clock; p.isec = m_isec_cnt; p.alm = m_alarm;
        p.alm_en = m_alarm_en; p.tgt = m_ttarget; p.rt = m_tretrig; p.ten = m_ten;
        return p;
    endfunction

    // A time of day in decimal terms: digits 0-9, hh<=23, mm/ss<=59.
    function automatic bit bcd_valid(input logic [31:0] d, input bit is_clock);
        int hh, mm, ss;
        bit ok;
        ok = (d[30:22] == 0) && (!is_clock || d[31] == 1'b0);
        ok = ok && d[3:0] < 10 && d[7:4] < 10 && d[11:8] < 10 && d[15:12] < 10 && d[19:16] < 10;
        hh = d[21:20] * 10 + d[19:16];
        mm = d[15:12] * 10 + d[11:8];
        ss = d[7:4] * 10 + d[3:0];
        return ok && hh <= 23 && mm <= 59 && ss <= 59;
    endfunction

    function automatic bit time_ok(input logic [31:0] d, input bit is_clock);
`ifdef RTC_BCD_CHECK_EN
        return bcd_valid(d, is_clock);
`else
        return (d[0] | ~d[0]) ? 1'b1 : bcd_valid(d, is_clock);
`endif
    endfunction

    function automatic logic [31:0] rand_time();
        int h, m, s;
        logic [31:0] d;
        h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
        d = '0;
        d[21:20] = 2'(h / 10); d[19:16] = 4'(h % 10);
        d[15:12] = 4'(m / 10); d[11:8]  = 4'(m % 10);
        d[7:4]   = 4'(s / 10); d[3:0]   = 4'(s % 10);
        return d;
    endfunction

    // APB response monitor: counts wait states and pops one expectation per completed transfer.
    int   wait_cnt = 0;
    exp_t mon_e;
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            wait_cnt = 0;
        end else if (PSEL && PENABLE) begin
            if (PREADY) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk({mon_e.name, "_pslverr"}, PSLVERR, mon_e.err);
                    chk({mon_e.name, "_waits"}, wait_cnt, mon_e.waits);
                    if (mon_e.is_rd) chk({mon_e.name, "_prdata"}, PRDATA, mon_e.rdata);
                end
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Load-pulse monitor: every pulse must match a queued expectation.
    pexp_t      mon_p;
    logic [2:0] mon_kind;
    always @(negedge clk_i) begin
        mon_kind = {clock_update_o, alarm_update_o, timer_update_o};
        if (mon_kind != 3'b000) begin
            if (pulse_q.size() == 0) begin
                chk("unexpected_pulse", mon_kind, 0);
            end else begin
                mon_p = pulse_q.pop_front();
                chk("pulse_kind", mon_kind, mon_p.kind);
                chk("pulse_clock_o", clock_o, mon_p.clk);
                chk("pulse_init_sec_cnt_o", init_sec_cnt_o, mon_p.isec);
                chk("pulse_alarm", {alarm_enable_o, alarm_clock_o}, {mon_p.alm_en, mon_p.alm});
                chk("pulse_timer", {timer_enable_o, timer_retrig_o, timer_target_o},
                    {mon_p.ten, mon_p.rt, mon_p.tgt});
            end
        end
    end

    // One APB transfer; optional event/day pulse coincident with the access cycle.
    task automatic apb(input logic [11:0] addr, input bit wr, input logic [31:0] data,
                       input bit c_evt, input bit c_day, input string name);
        exp_t e;
        logic [2:0] kind;
        bit dc_wr;
        int n;
        e.name = name; e.waits = 0; e.err = 0; e.is_rd = !wr; e.rdata = 0;
        kind = 0; dc_wr = 0;
        if (addr >= 12'h020) begin
            e.err = 1;
        end else if (!wr) begin
            case (addr[4:2])
                3'd0: e.rdata = {30'd0, m_day, m_evt};
                3'd1: e.rdata = {30'd0, m_ctrl};
                3'd2: e.rdata = {10'd0, clock_i};
                3'd3: e.rdata = {m_alarm_en, 9'd0, alarm_clock_i};
                3'd5: e.rdata = {15'd0, timer_value_i};
                3'd6: e.rdata = {22'd0, m_initsec};
                3'd7: e.rdata = {16'd0, m_daycnt};
                default: e.rdata = 0;
            endcase
        end else begin
            case (addr[4:2])
                3'd0: begin
                    if (data[0]) m_evt = 0;
                    if (data[1]) m_day = 0;
                end
                3'd1: m_ctrl = data[1:0];
                3'd2: if (time_ok(data, 1)) begin
                    m_clock = data[21:0]; m_isec_cnt = m_initsec; kind = 3'b100;
                end else e.err = 1;
                3'd3: if (time_ok(data, 0)) begin
                    m_alarm = data[21:0]; m_alarm_en = data[31]; kind = 3'b010;
                end else e.err = 1;
                3'd4: begin
                    m_ttarget = data[16:0]; m_tretrig = data[30]; m_ten = data[31]; kind = 3'b001;
                end
                3'd6: m_initsec = data[9:0];
                3'd7: begin m_daycnt = data[15:0]; dc_wr = 1; end
                default: ;
            endcase
        end
        if (kind != 0) begin
            e.waits = 1;
            pulse_q.push_back(snap(kind));
        end
        if (c_evt) m_evt = 1;
        if (c_day) begin
            m_day = 1;
            if (!dc_wr) m_daycnt++;
        end
        exp_q.push_back(e);
        PADDR = addr; PWRITE = wr; PWDATA = data; PSEL = 1; PENABLE = 0;
        tick();
        PENABLE = 1; event_i = c_evt; update_day_i = c_day;
        n = 0;
        while (1) begin
            @(negedge clk_i);
            if (PREADY) break;
            n++;
            if (n > 8) begin
                chk({name, "_timeout"}, 1, 0);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        event_i = 0; update_day_i = 0; PSEL = 0; PENABLE = 0;
        tick();
        chk({name, "_irq"}, irq_o, model_irq());
    endtask

    // Single-cycle event_i or update_day_i pulse; irq follows status by one cycle.
    task automatic pulse_in(input bit is_day);
        logic prev;
        prev = model_irq();
        if (is_day) update_day_i = 1; else event_i = 1;
        tick();
        event_i = 0; update_day_i = 0;
        if (is_day) begin m_day = 1; m_daycnt++; end else m_evt = 1;
        chk(is_day ? "day_irq_latency" : "evt_irq_latency", irq_o, prev);
        tick();
        chk(is_day ? "day_irq" : "evt_irq", irq_o, model_irq());
    endtask

    task automatic rand_inputs();
        clock_i = 22'($urandom); alarm_clock_i = 22'($urandom); timer_value_i = 17'($urandom);
    endtask

    logic [31:0] d;
    int          r;

    initial begin
        rstn_i = 0; PADDR = 0; PWDATA = 0; PWRITE = 0; PSEL = 1; PENABLE = 1;
        event_i = 0; update_day_i = 0;
        clock_i = 22'h123456; alarm_clock_i = 22'h0A0B0C; timer_value_i = 17'h1ABCD;
        model_reset();
        tick(); tick();
        chk("reset_outputs", all_outs, 0);
        PSEL = 0; PENABLE = 0; rstn_i = 1;
        tick();

        apb(12'h000, 0, 0, 0, 0, "rst_status");
        apb(12'h004, 0, 0, 0, 0, "rst_ctrl");
        apb(12'h01C, 0, 0, 0, 0, "rst_daycnt");

        apb(12'h018, 1, 32'h000001A5, 0, 0, "wr_initsec");
        apb(12'h018, 0, 0, 0, 0, "rd_initsec");
        apb(12'h008, 1, 32'h00235958, 0, 0, "wr_clock");
        apb(12'h008, 0, 0, 0, 0, "rd_clock");
        apb(12'h008, 1, 32'h0000005A, 0, 0, "wr_clock_5a");
        chk("clock_o_after_5a", clock_o, m_clock);

        apb(12'h004, 1, 32'h00000001, 0, 0, "wr_ctrl_evt");
        pulse_in(0);
        apb(12'h000, 0, 0, 0, 0, "rd_status_evt");
        apb(12'h000, 1, 32'h00000001, 0, 0, "w1c_evt");
        apb(12'h000, 1, 32'h00000001, 1, 0, "w1c_vs_evt");
        apb(12'h000, 0, 0, 0, 0, "rd_status_set_wins");

        apb(12'h01C, 1, 32'h0000FFFF, 0, 0, "wr_daycnt_ffff");
        pulse_in(1);
        apb(12'h01C, 0, 0, 0, 0, "rd_daycnt_wrap");
        apb(12'h000, 0, 0, 0, 0, "rd_status_day");
        apb(12'h01C, 1, 32'h00000005, 0, 1, "wr_daycnt_vs_day");
        apb(12'h01C, 0, 0, 0, 0, "rd_daycnt_write_wins");

        apb(12'h010, 1, 32'hC0000100, 0, 0, "wr_timer");
        apb(12'h010, 0, 0, 0, 0, "rd_timer_wo");
        timer_value_i = 17'h0F00D;
        apb(12'h014, 0, 0, 0, 0, "rd_tval");
        apb(12'h00C, 1, 32'h80123000, 0, 0, "wr_alarm");
        apb(12'h00C, 0, 0, 0, 0, "rd_alarm");
        apb(12'h020, 0, 0, 0, 0, "rd_unmapped");
        apb(12'h020, 1, 32'hFFFFFFFF, 0, 0, "wr_unmapped");

        // Timer write whose PSEL drops while the pulse is pending.
        m_ttarget = 17'h00AAA; m_tretrig = 0; m_ten = 1;
        pulse_q.push_back(snap(3'b001));
        PADDR = 12'h010; PWRITE = 1; PWDATA = 32'h80000AAA; PSEL = 1; PENABLE = 0;
        tick();
        PENABLE = 1;
        tick();
        PSEL = 0; PENABLE = 0;
        tick(); tick();
        chk("psel_drop_pulse_done", pulse_q.size(), 0);

        for (int i = 0; i < 100; i++) begin
            rand_inputs();
            r = $urandom_range(0, 9);
            case (r)
                0: apb({7'd0, 3'($urandom), 2'b00}, 0, 0, 0, 0, "rnd_read");
                1: apb(($urandom_range(0, 1) == 0) ? 12'h004 : 12'h014, 1, $urandom, 0, 0, "rnd_wr_ctrl");
                2: apb(12'h000, 1, $urandom, $urandom_range(0, 1) == 1, 0, "rnd_w1c");
                3: pulse_in(0);
                4: pulse_in(1);
                5: begin
                    d = rand_time();
                    if ($urandom_range(0, 3) == 0) d = $urandom;
                    apb(12'h008, 1, d, 0, 0, "rnd_clock");
                end
                6: apb(12'h00C, 1, rand_time() | {$urandom_range(0, 1) == 1, 31'd0}, 0, 0, "rnd_alarm");
                7: apb(12'h010, 1, $urandom, 0, 0, "rnd_timer");
                8: begin
                    d = ($urandom_range(0, 3) == 0) ? 32'h0000FFFF : $urandom;
                    apb(($urandom_range(0, 1) == 0) ? 12'h018 : 12'h01C, 1, d,
                        $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, "rnd_wr_misc");
                end
                default: apb(12'h020 + 12'(4 * $urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                             $urandom, 0, 0, "rnd_unmapped");
            endcase
        end

        // Reset asserted in the wait state of a CLOCK write: no pulse may follow.
        PADDR = 12'h008; PWRITE = 1; PWDATA = 32'h00121314; PSEL = 1; PENABLE = 0;
        tick();
        PENABLE = 1; rstn_i = 0;
        @(negedge clk_i);
        chk("midrst_pready", PREADY, 0);
        @(posedge clk_i);
        #1;
        PSEL = 0; PENABLE = 0;
        chk("midrst_outputs", all_outs, 0);
        tick(); tick();
        model_reset();
        rstn_i = 1;
        tick();
        apb(12'h000, 0, 0, 0, 0, "midrst_status");
        apb(12'h004, 0, 0, 0, 0, "midrst_ctrl");
        apb(12'h01C, 0, 0, 0, 0, "midrst_daycnt");
        apb(12'h00C, 0, 0, 0, 0, "midrst_alarm");

        tick(); tick();
        chk("apb_queue_drained", exp_q.size(), 0);
        chk("pulse_queue_drained", pulse_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
